// File: rtl/meta_dispatcher_pkg.sv
// Shared types for the metadata dispatch path: descriptor layout, packet flags,
// statistics bundle and the dispatcher buffer depth.
package meta_dispatcher_pkg;

    localparam int META_DISPATCHER_DEPTH = 2;
    localparam int DISPATCH_STAT_W       = 32;

    typedef enum logic [1:0] {
        PKT_PCIE = 2'd0,
        PKT_DROP = 2'd1,
        PKT_HOST = 2'd2,
        PKT_LOOP = 2'd3
    } pkt_flags_t;

    typedef struct packed {
        logic [31:0] pkt_queue_id;
        logic [15:0] pkt_size;
        pkt_flags_t  pkt_flags;
    } metadata_t;

    typedef struct packed {
        logic [DISPATCH_STAT_W-1:0] fwd;
        logic [DISPATCH_STAT_W-1:0] drop;
        logic [DISPATCH_STAT_W-1:0] oob;
    } dispatch_stats_t;

endpackage

// File: rtl/meta_skid_fifo.sv
// Two-entry FIFO with a registered push-side ready, so the downstream ready
// never reaches the upstream producer combinationally.
module meta_skid_fifo
    import meta_dispatcher_pkg::*;
#(
    parameter type T = metadata_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_valid,
    input  T     push_data,
    output logic push_ready,
    output logic pop_valid,
    output T     pop_data,
    input  logic pop_ready
);

    localparam logic [1:0] DEPTH = 2'(META_DISPATCHER_DEPTH);

    T           mem [META_DISPATCHER_DEPTH];
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       push;
    logic       pop;

    assign push      = push_valid && push_ready;
    assign pop       = pop_valid && pop_ready;
    assign pop_valid = (count != 2'd0);
    assign pop_data  = mem[head];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Ready is computed from the post-update occupancy so a pop while full
    // reopens the input on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            head       <= 1'b0;
            tail       <= 1'b0;
            push_ready <= 1'b0;
        end else begin
            count      <= count_next;
            push_ready <= (count_next < DEPTH);
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= push_data;
    end

endmodule

// File: rtl/meta_dispatcher.sv
// Drops PKT_DROP and out-of-range descriptors and buffers the rest in a 2-entry
// registered FIFO. Statistics counters exist only with META_DISPATCHER_STATS_EN.
module meta_dispatcher
    import meta_dispatcher_pkg::*;
#(
    parameter int QUEUE_ID_W = 32,
    parameter int STAT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  metadata_t         in_meta_data,
    input  logic              in_meta_valid,
    output logic              in_meta_ready,
    output metadata_t         out_meta_data,
    output logic              out_meta_valid,
    input  logic              out_meta_ready,
    input  logic [31:0]       conf_nb_queues,
    input  logic              conf_nb_queues_valid,
    output logic              conf_nb_queues_ready
`ifdef META_DISPATCHER_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_fwd,
    output logic [STAT_W-1:0] stat_drop,
    output logic [STAT_W-1:0] stat_oob
`endif
);

    logic [31:0] nb_queues;
    logic [31:0] queue_id;
    logic        accept;
    logic        is_drop;
    logic        is_oob;
    logic        is_fwd;

    assign conf_nb_queues_ready = 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb_queues <= 32'd0;
        end else if (conf_nb_queues_valid) begin
            nb_queues <= conf_nb_queues;
        end
    end

    always_comb begin
        queue_id                 = '0;
        queue_id[QUEUE_ID_W-1:0] = in_meta_data.pkt_queue_id[QUEUE_ID_W-1:0];
    end

    // Drop flag wins over the range check; a zero queue count disables the check.
    assign accept  = in_meta_valid && in_meta_ready;
    assign is_drop = (in_meta_data.pkt_flags == PKT_DROP);
    assign is_oob  = !is_drop && (nb_queues != 32'd0) && (queue_id >= nb_queues);
    assign is_fwd  = !is_drop && !is_oob;

    meta_skid_fifo #(
        .T(metadata_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_valid(accept && is_fwd),
        .push_data (in_meta_data),
        .push_ready(in_meta_ready),
        .pop_valid (out_meta_valid),
        .pop_data  (out_meta_data),
        .pop_ready (out_meta_ready)
    );

`ifdef META_DISPATCHER_STATS_EN
    // A clear coinciding with an event keeps that event, hence 1 rather than 0.
    function automatic logic [STAT_W-1:0] stat_next(input logic [STAT_W-1:0] cur,
                                                    input logic clr,
                                                    input logic ev);
        if (clr) return ev ? STAT_W'(1) : '0;
        if (ev)  return (&cur) ? cur : cur + 1'b1;
        return cur;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd  <= '0;
            stat_drop <= '0;
            stat_oob  <= '0;
        end else begin
            stat_fwd  <= stat_next(stat_fwd,  stat_clr, accept && is_fwd);
            stat_drop <= stat_next(stat_drop, stat_clr, accept && is_drop);
            stat_oob  <= stat_next(stat_oob,  stat_clr, accept && is_oob);
        end
    end
`endif

endmodule

// File: tb/tb_meta_dispatcher.sv
// Scoreboard bench for meta_dispatcher; statistics checks compile in with
// META_DISPATCHER_STATS_EN.
module tb_meta_dispatcher;
    import meta_dispatcher_pkg::*;

    localparam int SW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    metadata_t   in_meta_data;
    logic        in_meta_valid;
    logic        in_meta_ready;
    metadata_t   out_meta_data;
    logic        out_meta_valid;
    logic        out_meta_ready;
    logic [31:0] conf_nb_queues;
    logic        conf_nb_queues_valid;
    logic        conf_nb_queues_ready;
`ifdef META_DISPATCHER_STATS_EN
    logic          stat_clr;
    logic [SW-1:0] stat_fwd;
    logic [SW-1:0] stat_drop;
    logic [SW-1:0] stat_oob;
    int            exp_fwd = 0;
    int            exp_drop = 0;
    int            exp_oob = 0;
`endif

    meta_dispatcher #(
        .QUEUE_ID_W(32),
        .STAT_W    (SW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_meta_data        (in_meta_data),
        .in_meta_valid       (in_meta_valid),
        .in_meta_ready       (in_meta_ready),
        .out_meta_data       (out_meta_data),
        .out_meta_valid      (out_meta_valid),
        .out_meta_ready      (out_meta_ready),
        .conf_nb_queues      (conf_nb_queues),
        .conf_nb_queues_valid(conf_nb_queues_valid),
        .conf_nb_queues_ready(conf_nb_queues_ready)
`ifdef META_DISPATCHER_STATS_EN
        ,
        .stat_clr            (stat_clr),
        .stat_fwd            (stat_fwd),
        .stat_drop           (stat_drop),
        .stat_oob            (stat_oob)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        metadata_t d;
        int        cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    bit          lat_chk = 1'b0;
    bit          sb_en = 1'b1;
    logic [31:0] model_nbq = 32'd0;
    bit          prev_stall = 1'b0;
    metadata_t   prev_data;

    function automatic metadata_t mk(input logic [31:0] q, input pkt_flags_t f);
        metadata_t m;
        m.pkt_queue_id = q;
        m.pkt_size     = 16'h0040 ^ q[15:0];
        m.pkt_flags    = f;
        return m;
    endfunction

`ifdef META_DISPATCHER_STATS_EN
    function automatic int sat(input int v);
        int mx = (1 << SW) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_stats(input string tag);
        check({tag, "_fwd"},  64'(stat_fwd),  64'(exp_fwd));
        check({tag, "_drop"}, 64'(stat_drop), 64'(exp_drop));
        check({tag, "_oob"},  64'(stat_oob),  64'(exp_oob));
    endtask
`endif

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_meta_valid), 64'(1));
                check("hold_data", 64'(out_meta_data), 64'(prev_data));
            end
            if (out_meta_valid && out_meta_ready) begin
                if (sb.size() == 0) begin
                    check("out_unexpected", 64'(out_meta_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(out_meta_data), 64'(e.d));
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(0));
                end
            end
            prev_stall = out_meta_valid && !out_meta_ready;
            prev_data  = out_meta_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input metadata_t d, output int acc);
        bit done = 1'b0;
        in_meta_valid = 1'b1;
        in_meta_data  = d;
        acc = -1;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (in_meta_ready) done = 1'b1;
            tick();
        end
        in_meta_valid = 1'b0;
        if (!done) begin
            check("accept_timeout", 64'(in_meta_ready), 64'(1));
        end else begin
            acc = cyc;
            if (d.pkt_flags == PKT_DROP) begin
`ifdef META_DISPATCHER_STATS_EN
                exp_drop = sat(exp_drop + 1);
`endif
            end else if (model_nbq != 32'd0 && d.pkt_queue_id >= model_nbq) begin
`ifdef META_DISPATCHER_STATS_EN
                exp_oob = sat(exp_oob + 1);
`endif
            end else begin
`ifdef META_DISPATCHER_STATS_EN
                exp_fwd = sat(exp_fwd + 1);
`endif
                if (sb_en) sb.push_back('{d, acc});
            end
        end
    endtask

    task automatic conf(input logic [31:0] v);
        conf_nb_queues       = v;
        conf_nb_queues_valid = 1'b1;
        tick();
        conf_nb_queues_valid = 1'b0;
        model_nbq            = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc0;
        int raise;
        int acc_c;
        in_meta_valid        = 1'b0;
        in_meta_data         = '0;
        out_meta_ready       = 1'b0;
        conf_nb_queues       = 32'd0;
        conf_nb_queues_valid = 1'b0;
`ifdef META_DISPATCHER_STATS_EN
        stat_clr             = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_meta_ready), 64'(0));
        check("rst_out_valid", 64'(out_meta_valid), 64'(0));
        check("conf_ready", 64'(conf_nb_queues_ready), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 64'(in_meta_ready), 64'(0));
        tick();
        check("ready_after_release", 64'(in_meta_ready), 64'(1));

        // Back-to-back forwarding, range check disabled.
        out_meta_ready = 1'b1;
        lat_chk = 1'b1;
        for (int q = 0; q < 4; q++) begin
            send(mk(32'(q), PKT_PCIE), acc);
            if (q == 0) acc0 = acc;
            check("b2b_accept_cycle", 64'(acc), 64'(acc0 + q));
        end
        lat_chk = 1'b0;
        repeat (2) tick();
`ifdef META_DISPATCHER_STATS_EN
        check_stats("t1");
`endif

        // Backpressure: buffer fills after two beats.
        out_meta_ready = 1'b0;
        send(mk(32'd10, PKT_PCIE), acc);
        send(mk(32'd11, PKT_HOST), acc);
        check("full_ready_low", 64'(in_meta_ready), 64'(0));
        check("full_out_valid", 64'(out_meta_valid), 64'(1));
        fork
            send(mk(32'd12, PKT_LOOP), acc_c);
            begin
                repeat (3) tick();
                out_meta_ready = 1'b1;
                raise = cyc;
            end
        join
        check("third_accept_cycle", 64'(acc_c), 64'(raise + 2));
        repeat (4) tick();
        check("drain_t2", 64'(out_meta_valid), 64'(0));

        // Drop-flagged beat is discarded.
        send(mk(32'd7, PKT_DROP), acc);
        send(mk(32'd5, PKT_PCIE), acc);
        repeat (3) tick();
`ifdef META_DISPATCHER_STATS_EN
        check_stats("t3");
`endif

        // Queue range check.
        conf(32'd4);
        send(mk(32'd3, PKT_PCIE), acc);
        send(mk(32'd4, PKT_PCIE), acc);
        send(mk(32'hFFFF_FFFF, PKT_PCIE), acc);
        conf(32'd8);
        send(mk(32'd4, PKT_HOST), acc);
        repeat (3) tick();
        check("sb_empty_t4", 64'(sb.size()), 64'(0));
`ifdef META_DISPATCHER_STATS_EN
        check_stats("t4");

        // Saturation, then clear coinciding with a forward.
        while (exp_fwd < (1 << SW) - 1) send(mk(32'd1, PKT_PCIE), acc);
        send(mk(32'd2, PKT_PCIE), acc);
        check("fwd_saturated", 64'(stat_fwd), 64'((1 << SW) - 1));
        repeat (2) tick();
        check("clr_ready", 64'(in_meta_ready), 64'(1));
        stat_clr = 1'b1;
        send(mk(32'd6, PKT_PCIE), acc);
        stat_clr = 1'b0;
        exp_fwd  = 1;
        exp_drop = 0;
        exp_oob  = 0;
        check_stats("clr");
        repeat (2) tick();
`endif

        // Reset in the middle of traffic with two buffered entries.
        out_meta_ready = 1'b0;
        sb_en = 1'b0;
        send(mk(32'd1, PKT_PCIE), acc);
        send(mk(32'd2, PKT_PCIE), acc);
        check("pre_rst_valid", 64'(out_meta_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_meta_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_meta_ready), 64'(0));
`ifdef META_DISPATCHER_STATS_EN
        exp_fwd  = 0;
        exp_drop = 0;
        exp_oob  = 0;
        check_stats("mid_rst");
`endif
        sb.delete();
        sb_en = 1'b1;
        model_nbq = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 64'(in_meta_ready), 64'(1));
        check("post_rst_empty", 64'(out_meta_valid), 64'(0));
        out_meta_ready = 1'b1;
        send(mk(32'd9, PKT_PCIE), acc);
        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/meta_dispatcher.md
# meta_dispatcher

Metadata stage directly downstream of the flow director. It consumes per-packet `metadata_t` and discards descriptors flagged `PKT_DROP`. It also discards descriptors whose `pkt_queue_id` is outside the configured queue range. All surviving descriptors pass through a 2-entry registered buffer, which breaks the combinational ready path from the packet-queue side back through the flow director.

## Interface
Parameters:
- `QUEUE_ID_W`, default 32: width compared from `pkt_queue_id`; the low `QUEUE_ID_W` bits are used.
- `STAT_W`, default 32: width of each statistics counter.

Ports:
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_meta_data`, in, `metadata_t`: descriptor from the flow director.
- `in_meta_valid`, in, 1: descriptor valid.
- `in_meta_ready`, out, 1: stage accepts the descriptor; driven directly from a flop.
- `out_meta_data`, out, `metadata_t`: forwarded descriptor, unmodified.
- `out_meta_valid`, out, 1: buffer head valid.
- `out_meta_ready`, in, 1: downstream accepts.
- `conf_nb_queues`, in, 32: number of valid queues; 0 disables the range check.
- `conf_nb_queues_valid`, in, 1: load `conf_nb_queues`.
- `conf_nb_queues_ready`, out, 1: tied to 1.
- `stat_clr`, in, 1: synchronous clear of all counters (present only with the macro).
- `stat_fwd`, `stat_drop`, `stat_oob`, out, `STAT_W` each: statistics counters (present only with the macro).

## Operation
- Input beat accepted when `in_meta_valid && in_meta_ready`.
- Classification, priority order:
  - `pkt_flags == PKT_DROP` → discard; `drop` event.
  - `nb_queues != 0 && pkt_queue_id >= nb_queues` (unsigned, 32-bit compare) → discard; `oob` event.
  - Otherwise → push into the buffer; `fwd` event.
- Flags other than `PKT_DROP` are forwarded untouched. The stage never rewrites any field.
- Buffer: 2-entry FIFO with head and tail pointers (1 bit each) and a 2-bit count.
  - `out_meta_valid = (count != 0)`.
  - `out_meta_data` = head entry.
  - Pop on `out_meta_valid && out_meta_ready`.
- `in_meta_ready` is a register. Its next value is 1 when the next count < 2; otherwise 0.
  - Discarded beats never occupy the buffer, but they are accepted only while `in_meta_ready` is 1.
- Config register `nb_queues`:
  - Loaded when `conf_nb_queues_valid` is high.
  - Applies to beats accepted from the following cycle on.
  - Reset value 0, so the range check is disabled until configured.

## Timing
- Reset (`rst_n` low, asynchronous): count=0, pointers=0, `in_meta_ready`=0, `out_meta_valid`=0, `nb_queues`=0, counters=0. `out_meta_data` is don't-care while `out_meta_valid`=0.
- The first rising edge after `rst_n` deasserts sets `in_meta_ready`=1.
- Latency: a beat accepted at edge N appears on `out_meta_*` in cycle N+1.
- Throughput: 1 beat per cycle while `out_meta_ready`=1.
- Count 1, push and pop in the same cycle → count stays 1, pointers both advance, `in_meta_ready` stays 1.
- Count 2 → `in_meta_ready`=0. A pop in that cycle raises `in_meta_ready` for the next cycle.
- Count 0, push → `out_meta_valid` next cycle. The stage has no same-cycle bypass.
- Pointers wrap modulo 2.
- Once asserted, `out_meta_valid` and `out_meta_data` stay stable until popped (AXI-stream rule).
- `rst_n` asserted mid-traffic: buffered descriptors are lost and counters are cleared, with no output glitch beyond `out_meta_valid` falling.

## Configuration
- Macro: `META_DISPATCHER_STATS_EN`.
- Defined:
  - `stat_fwd`, `stat_drop`, `stat_oob` count their respective accepted events.
  - Counters saturate at 2^`STAT_W`-1.
  - If `stat_clr` and an event occur in the same cycle, the counter becomes 1.
- Undefined: `stat_clr` and the `stat_*` ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package (alongside `metadata_t`, `PKT_DROP`, `PKT_PCIE`):
  - `dispatch_stats_t`, a struct of the three counters.
  - Constant `META_DISPATCHER_DEPTH = 2`.
- One sub-module: `meta_skid_fifo`, the 2-entry FIFO with registered ready, parameterised on the element type.
- Classification and counters remain in `meta_dispatcher`.

## Test plan
- Reset release, `out_meta_ready`=1, 4 back-to-back `PKT_PCIE` beats with queue 0..3, `nb_queues`=0 → `in_meta_ready` rises 1 cycle after release; outputs queue 0..3 in cycles N+1..N+4; `stat_fwd`=4.
- `out_meta_ready`=0, 3 valid beats → first two accepted, `in_meta_ready`=0 from the next cycle. Raise `out_meta_ready` → third beat accepted the cycle after the first pop; order preserved.
- Beat with `PKT_DROP`, then beat with queue 5 → output shows only queue 5; `stat_drop`=1.
- `nb_queues`=4 configured, beats with queue 3, 4, 0xFFFFFFFF → only queue 3 forwarded; `stat_oob`=2. Reconfigure to 8 → queue 4 forwarded.
- Preload `stat_fwd` to 2^32-1, one more forward → stays 2^32-1. Assert `stat_clr` with a forward in the same cycle → `stat_fwd`=1.
- Assert `rst_n` low with 2 buffered entries → `out_meta_valid`=0 and `in_meta_ready`=0 immediately, all counters 0.
